// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 telephone keypad matrix, rejects multi-key
// presses, debounces whole-scan results and presents the accepted key as
// one-hot digit levels, star/hash levels, a key code and a one-cycle strobe.
module keypad_scanner #(
    parameter int SCAN_DIV       = 2,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       star,
    output logic       hash,
    output logic [3:0] key_code,
    output logic       key_strobe
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [3:0]    KEY_NONE   = 4'hF;

    // Key code at a matrix position: rows 0-2 hold 1..9, row 3 holds *,0,#.
    function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = 4'd10;
                2'd1:    code = 4'd0;
                default: code = 4'd11;
            endcase
        end else begin
            code = 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
        end
        return code;
    endfunction

    // Scanner state
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    // Accumulator: hit count saturates at 2 (meaning "two or more")
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;
    // Debounce state
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    stable_q, stable_d;
    // Registered outputs
    logic [9:0]    keypad_q, keypad_d;
    logic          star_q, star_d;
    logic          hash_q, hash_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_strobe_q, key_strobe_d;

    logic          sample;
    logic          scan_end;
    logic [1:0]    row_hits;
    logic [3:0]    row_code;
    logic [2:0]    hit_sum;
    logic [1:0]    seen_cnt;
    logic [3:0]    seen_code;
    logic [3:0]    raw;
    logic          advanced;

    assign sample   = (dwell_q == DWELL_LAST);
    assign scan_end = sample && (row_q == 2'd3);
    assign row_n    = ~(4'b0001 << row_q);

    // Dwell counter and row index: advance row after the last dwell cycle.
    always_comb begin
        dwell_d = dwell_q + DW'(1);
        row_d   = row_q;
        if (sample) begin
            dwell_d = '0;
            row_d   = row_q + 2'd1;
        end
    end

    // Fold the columns of the current row into the scan accumulator; the
    // scan result is formed from the accumulator including the last row.
    always_comb begin
        row_hits = 2'd0;
        row_code = acc_code_q;
        for (int c = 0; c < 3; c++) begin
            if (!col_n[c]) begin
                row_hits = row_hits + 2'd1;
                row_code = key_at(row_q, 2'(c));
            end
        end
        hit_sum   = {1'b0, acc_cnt_q} + {1'b0, row_hits};
        seen_cnt  = acc_cnt_q;
        seen_code = acc_code_q;
        if (sample) begin
            seen_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
            seen_code = row_code;
        end
        raw        = (seen_cnt == 2'd1) ? seen_code : KEY_NONE;
        acc_cnt_d  = scan_end ? 2'd0 : seen_cnt;
        acc_code_d = scan_end ? KEY_NONE : seen_code;
    end

    // Debounce: commit the candidate once it has been seen on enough
    // consecutive scans; a saturated count holds without re-committing.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        advanced = 1'b0;
        if (scan_end) begin
            if (raw != cand_q) begin
                cand_d   = raw;
                cnt_d    = CNT_ONE;
                advanced = 1'b1;
            end else if (cnt_q < CNT_FULL) begin
                cnt_d    = cnt_q + CNT_ONE;
                advanced = 1'b1;
            end
            if (advanced && (cnt_d == CNT_FULL)) begin
                stable_d = cand_d;
            end
        end
    end

    // Output decode from the next stable value so levels and strobe land on
    // the same edge that commits the key.
    always_comb begin
        keypad_d     = (stable_d < 4'd10) ? (10'd1 << stable_d) : 10'd0;
        star_d       = (stable_d == 4'd10);
        hash_d       = (stable_d == 4'd11);
        key_code_d   = stable_d;
        key_strobe_d = (stable_d != stable_q) && (stable_d != KEY_NONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            dwell_q      <= '0;
            row_q        <= 2'd0;
            acc_cnt_q    <= 2'd0;
            acc_code_q   <= KEY_NONE;
            cand_q       <= KEY_NONE;
            cnt_q        <= '0;
            stable_q     <= KEY_NONE;
            keypad_q     <= 10'd0;
            star_q       <= 1'b0;
            hash_q       <= 1'b0;
            key_code_q   <= KEY_NONE;
            key_strobe_q <= 1'b0;
        end else begin
            dwell_q      <= dwell_d;
            row_q        <= row_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_code_q   <= acc_code_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            keypad_q     <= keypad_d;
            star_q       <= star_d;
            hash_q       <= hash_d;
            key_code_q   <= key_code_d;
            key_strobe_q <= key_strobe_d;
        end
    end

    assign keypad     = keypad_q;
    assign star       = star_q;
    assign hash       = hash_q;
    assign key_code   = key_code_q;
    assign key_strobe = key_strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix driven by a pressed-key
// mask, a scan-level reference model, directed scenarios and random presses.
module tb_keypad_scanner;

    localparam int SD   = 2;
    localparam int DEB  = 3;
    localparam int SCAN = 4 * SD;

    logic       clk = 1'b0;
    logic       clear;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       star;
    logic       hash;
    logic [3:0] key_code;
    logic       key_strobe;

    logic [11:0] mask;
    int key_map [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

    // Reference model state
    int         cyc;
    int         seen_cnt;
    int         seen_key;
    int         raws[$];
    int         exp_stable;
    bit         exp_strobe;
    logic [3:0] exp_q[$];

    int n_checks;
    int n_pass;
    int strobe_cnt;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .clear(clear), .col_n(col_n), .row_n(row_n),
        .keypad(keypad), .star(star), .hash(hash),
        .key_code(key_code), .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    // Key matrix: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!row_n[r] && mask[key_map[r][c]]) col_n[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        cyc        = 0;
        seen_cnt   = 0;
        seen_key   = 15;
        raws.delete();
        exp_stable = 15;
        exp_strobe = 1'b0;
        exp_q.delete();
    endtask

    // One clock of the model: columns of row r are looked at on the last
    // dwell cycle of that row; each full scan yields a key or none, and the
    // key is accepted once DEB consecutive scans agree.
    task automatic model_step();
        int  pos;
        int  r;
        int  raw;
        bit  same;
        pos        = cyc % SCAN;
        exp_strobe = 1'b0;
        if ((pos % SD) == SD - 1) begin
            r = pos / SD;
            for (int c = 0; c < 3; c++)
                if (mask[key_map[r][c]]) begin
                    seen_cnt++;
                    seen_key = key_map[r][c];
                end
            if (r == 3) begin
                raw = (seen_cnt == 1) ? seen_key : 15;
                raws.push_back(raw);
                if (raws.size() > DEB) void'(raws.pop_front());
                same = (raws.size() == DEB);
                foreach (raws[i]) if (raws[i] != raw) same = 1'b0;
                if (same && raw != exp_stable) begin
                    exp_stable = raw;
                    if (raw != 15) begin
                        exp_strobe = 1'b1;
                        exp_q.push_back(4'(raw));
                    end
                end
                seen_cnt = 0;
                seen_key = 15;
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        logic [3:0] e_row;
        logic [9:0] e_kp;
        e_row = 4'b1111;
        e_row[(cyc / SD) % 4] = 1'b0;
        e_kp = (exp_stable < 10) ? (10'd1 << exp_stable) : 10'd0;
        check("row_n", 16'(row_n), 16'(e_row));
        check("keypad", 16'(keypad), 16'(e_kp));
        check("star", 16'(star), 16'(exp_stable == 10));
        check("hash", 16'(hash), 16'(exp_stable == 11));
        check("key_code", 16'(key_code), 16'(exp_stable));
        check("key_strobe", 16'(key_strobe), 16'(exp_strobe));
    endtask

    task automatic tick();
        logic [3:0] e_code;
        @(posedge clk);
        if (!clear) model_step();
        @(negedge clk);
        check_all();
        if (key_strobe === 1'b1) begin
            strobe_cnt++;
            check("strobe_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) begin
                e_code = exp_q.pop_front();
                check("strobe_code", 16'(key_code), 16'(e_code));
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance to a negedge where a new scan is about to begin.
    task automatic align();
        for (int i = 0; i < SCAN && (cyc % SCAN) != 0; i++) tick();
    endtask

    // Assert clear at the current negedge and check the immediate effect.
    task automatic assert_clear(input string tag);
        clear = 1'b1;
        model_reset();
        #1;
        check({tag, "_keypad"}, 16'(keypad), 16'd0);
        check({tag, "_code"}, 16'(key_code), 16'hF);
        check({tag, "_row_n"}, 16'(row_n), 16'b1110);
        check({tag, "_strobe"}, 16'(key_strobe), 16'd0);
    endtask

    initial begin
        logic [11:0] m;
        int k1;
        int k2;
        n_checks   = 0;
        n_pass     = 0;
        strobe_cnt = 0;
        mask       = 12'd0;
        clear      = 1'b1;
        model_reset();

        // Power-on reset
        @(negedge clk);
        check("rst_keypad", 16'(keypad), 16'd0);
        check("rst_code", 16'(key_code), 16'hF);
        check("rst_row_n", 16'(row_n), 16'b1110);
        ticks(2);
        clear = 1'b0;

        // Press and release 1
        align();
        strobe_cnt = 0;
        mask = 12'b1 << 1;
        ticks(23);
        check("p1_not_early", 16'(keypad), 16'd0);
        tick();
        check("p1_keypad", 16'(keypad), 16'b0000000010);
        check("p1_code", 16'(key_code), 16'd1);
        ticks(76);
        check("p1_one_strobe", 16'(strobe_cnt), 16'd1);
        align();
        strobe_cnt = 0;
        mask = 12'd0;
        ticks(23);
        check("r1_not_early", 16'(keypad), 16'b0000000010);
        tick();
        check("r1_keypad", 16'(keypad), 16'd0);
        check("r1_no_strobe", 16'(strobe_cnt), 16'd0);

        // Bounce on 7, then hold
        align();
        strobe_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            mask = (i % 2 == 0) ? (12'b1 << 7) : 12'd0;
            ticks(5);
        end
        check("b7_no_strobe", 16'(strobe_cnt), 16'd0);
        check("b7_keypad_idle", 16'(keypad), 16'd0);
        mask = 12'b1 << 7;
        ticks(32);
        check("b7_keypad", 16'(keypad), 16'b0010000000);
        check("b7_one_strobe", 16'(strobe_cnt), 16'd1);

        // Two keys 2 and 5 together, then release 5
        mask = 12'd0;
        ticks(32);
        strobe_cnt = 0;
        mask = (12'b1 << 2) | (12'b1 << 5);
        ticks(100);
        check("dual_keypad", 16'(keypad), 16'd0);
        check("dual_code", 16'(key_code), 16'hF);
        check("dual_no_strobe", 16'(strobe_cnt), 16'd0);
        mask = 12'b1 << 2;
        ticks(32);
        check("k2_keypad", 16'(keypad), 16'b0000000100);
        check("k2_one_strobe", 16'(strobe_cnt), 16'd1);

        // Star, then directly hash
        mask = 12'd0;
        ticks(32);
        strobe_cnt = 0;
        mask = 12'b1 << 10;
        ticks(32);
        check("star_level", 16'(star), 16'd1);
        check("star_keypad", 16'(keypad), 16'd0);
        check("star_code", 16'(key_code), 16'd10);
        mask = 12'b1 << 11;
        ticks(32);
        check("hash_level", 16'(hash), 16'd1);
        check("hash_star_off", 16'(star), 16'd0);
        check("hash_code", 16'(key_code), 16'd11);
        check("star_hash_strobes", 16'(strobe_cnt), 16'd2);

        // Clear mid-scan with 5 accepted
        mask = 12'b1 << 5;
        ticks(40);
        check("k5_keypad", 16'(keypad), 16'b0000100000);
        ticks(3);
        assert_clear("clr5");
        tick();
        clear = 1'b0;
        ticks(23);
        check("clr5_not_early", 16'(keypad), 16'd0);
        tick();
        check("clr5_keypad", 16'(keypad), 16'b0000100000);

        // Clear while the debounce count is 2 on key 0
        mask = 12'd0;
        ticks(32);
        align();
        mask = 12'b1 << 0;
        ticks(18);
        assert_clear("clr0");
        tick();
        clear = 1'b0;
        ticks(23);
        check("clr0_not_early", 16'(keypad), 16'd0);
        tick();
        check("clr0_keypad", 16'(keypad), 16'b0000000001);
        check("clr0_code", 16'(key_code), 16'd0);

        // Random presses, releases, multi-presses and occasional clears
        for (int s = 0; s < 40; s++) begin
            k1 = $urandom_range(0, 11);
            k2 = $urandom_range(0, 11);
            case ($urandom_range(0, 9))
                0, 1:    m = 12'd0;
                2:       m = (12'b1 << k1) | (12'b1 << k2);
                default: m = 12'b1 << k1;
            endcase
            mask = m;
            ticks($urandom_range(2, 40));
            if ($urandom_range(0, 9) == 0) begin
                assert_clear("rnd_clr");
                ticks($urandom_range(1, 2));
                clear = 1'b0;
            end
        end
        mask = 12'd0;
        ticks(40);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
